// File: rtl/md_sequencer_pkg.sv
// ============================================================================
// Module   : md_sequencer_pkg
// Brief    : md_op encodings, default latencies and FSM states for md_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_sequencer_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
// Module   : md_arith
// Brief    : Combinational 64-bit {hi,lo} result for mult/multu/div/divu,
//            including the lo=all-ones / hi=dividend divide-by-zero result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result
);

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_divzero;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed  = md_is_signed(md_op);
  assign w_a_neg   = w_signed & rs_val[31];
  assign w_b_neg   = w_signed & rt_val[31];
  assign w_divzero = (rt_val == 32'd0);

  // Low 64 bits of the extended product equal the signed product.
  assign w_a_ext = {{32{w_a_neg}}, rs_val};
  assign w_b_ext = {{32{w_b_neg}}, rt_val};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide magnitudes, then restore signs: quotient toward zero,
  // remainder takes the dividend sign. 0x80000000 magnitude stays 0x80000000.
  assign w_a_mag = w_a_neg ? (~rs_val + 32'd1) : rs_val;
  assign w_b_mag = w_b_neg ? (~rt_val + 32'd1) : rt_val;
  assign w_den   = w_divzero ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_den;
  assign w_r_mag = w_a_mag % w_den;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    result = 64'd0;
    case (md_op)
      MD_MULT, MD_MULTU: result = w_prod;
      MD_DIV, MD_DIVU:   result = w_divzero ? {rs_val, 32'hFFFF_FFFF} : {w_rem, w_quot};
      default:           result = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module   : md_sequencer
// Brief    : Multi-cycle mult/div sequencer and HI/LO owner. Define
//            MD_DIVZERO_KEEP_EN to leave hi/lo untouched on divide by zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        md_active,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      r_lo;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      w_pend_hi_nxt;
  logic [31:0]      r_pend_lo;
  logic [31:0]      w_pend_lo_nxt;
  logic             w_accept;
  logic             w_commit;
  logic [63:0]      w_result;

`ifdef MD_DIVZERO_KEEP_EN
  logic             r_pend_keep;
  logic             w_pend_keep_nxt;
  logic             w_divzero;

  assign w_divzero = (rt_val == 32'd0);
  assign w_commit  = ~r_pend_keep;
`else
  assign w_commit  = 1'b1;
`endif

  md_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .result (w_result)
  );

  assign w_accept = start & ~flush & (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
`ifdef MD_DIVZERO_KEEP_EN
    w_pend_keep_nxt = r_pend_keep;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              w_pend_hi_nxt = w_result[63:32];
              w_pend_lo_nxt = w_result[31:0];
              w_cnt_nxt     = C_MULT_CNT;
              w_busy_nxt    = 1'b1;
              w_state_nxt   = ST_BUSY;
`ifdef MD_DIVZERO_KEEP_EN
              w_pend_keep_nxt = 1'b0;
`endif
            end
            MD_DIV, MD_DIVU: begin
              w_pend_hi_nxt = w_result[63:32];
              w_pend_lo_nxt = w_result[31:0];
              w_cnt_nxt     = C_DIV_CNT;
              w_busy_nxt    = 1'b1;
              w_state_nxt   = ST_BUSY;
`ifdef MD_DIVZERO_KEEP_EN
              w_pend_keep_nxt = w_divzero;
`endif
            end
            MD_MTHI: w_hi_nxt = rs_val;
            MD_MTLO: w_lo_nxt = rs_val;
            default: ;
          endcase
        end
      end

      ST_BUSY: begin
        // start/flush are deliberately ignored: the op already left E.
        w_cnt_nxt = r_cnt - C_CNT_ONE;
        if (r_cnt == C_CNT_ONE) begin
          if (w_commit) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

`ifdef MD_DIVZERO_KEEP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_keep <= 1'b0;
    end else begin
      r_pend_keep <= w_pend_keep_nxt;
    end
  end
`endif

  assign busy      = r_busy;
  assign md_active = (start & ~flush) | r_busy;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
// Module   : tb_md_sequencer
// Brief    : Scoreboard bench for md_sequencer (result queue + snapshot queue).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        md_active;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .busy      (busy),
    .md_active (md_active),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } res_t;

  typedef struct {
    int          id;
    logic        busy;
    logic        act;
    logic [31:0] hi;
    logic [31:0] lo;
  } snap_t;

  res_t  res_q[$];
  snap_t snap_q[$];
  logic  snap_go;
  logic  done;
  int    nchk;
  int    nerr;
  int    sid;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    res_t  e;
    snap_t s;
    int    blen;
    int    cyc;
    int    rcnt;
    logic  prev_busy;
    logic  prev_reset;
    nchk = 0; nerr = 0; blen = 0; cyc = 0; rcnt = 0;
    prev_busy = 1'b0; prev_reset = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) blen++;
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        if (prev_reset) begin
          blen = 0;
        end else if (res_q.size() == 0) begin
          chk("unexpected_commit", 32'd1, 32'd0);
          blen = 0;
        end else begin
          e = res_q.pop_front();
          rcnt++;
          chk($sformatf("res%0d.hi", rcnt), hi, e.hi);
          chk($sformatf("res%0d.lo", rcnt), lo, e.lo);
          chk($sformatf("res%0d.busy_len", rcnt), 32'(blen), 32'(e.len));
          blen = 0;
        end
      end
      if (snap_go === 1'b1 && snap_q.size() != 0) begin
        s = snap_q.pop_front();
        chk($sformatf("snap%0d.busy", s.id), {31'd0, busy}, {31'd0, s.busy});
        chk($sformatf("snap%0d.md_active", s.id), {31'd0, md_active}, {31'd0, s.act});
        chk($sformatf("snap%0d.hi", s.id), hi, s.hi);
        chk($sformatf("snap%0d.lo", s.id), lo, s.lo);
      end
      prev_busy  = busy;
      prev_reset = reset;
      if (done === 1'b1 || cyc > 20000) begin
        chk("timeout", {31'd0, done}, 32'd1);
        chk("pending_results", 32'(res_q.size()), 32'd0);
        chk("pending_snaps", 32'(snap_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic snap(input logic b, input logic a, input logic [31:0] h, input logic [31:0] l);
    snap_t s;
    s.id = sid; s.busy = b; s.act = a; s.hi = h; s.lo = l;
    sid++;
    snap_q.push_back(s);
    snap_go = 1'b1;
    @(posedge clk); #1;
    snap_go = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int len);
    res_t r;
    r.hi = eh; r.lo = el; r.len = len;
    res_q.push_back(r);
    issue(op, a, b);
    snap(1'b1, 1'b1, m_hi, m_lo);  // old hi/lo held while busy
    wait_idle();
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    res_t r;
    int   n;
    reset = 1'b1; start = 1'b0; flush = 1'b0; md_op = 3'd0;
    rs_val = 32'd0; rt_val = 32'd0; snap_go = 1'b0; done = 1'b0;
    sid = 0; m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    snap(1'b0, 1'b0, 32'd0, 32'd0);

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    run_op(MD_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 5);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op(MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10);

    // mthi then mtlo on consecutive cycles
    start = 1'b1; md_op = MD_MTHI; rs_val = 32'h1234_5678;
    snap(1'b0, 1'b1, 32'd1, 32'd3);
    md_op = MD_MTLO; rs_val = 32'h9ABC_DEF0;
    snap(1'b0, 1'b1, 32'h1234_5678, 32'd3);
    start = 1'b0;
    snap(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // flushed start is ignored, as is an unused opcode
    start = 1'b1; flush = 1'b1; md_op = MD_MULT; rs_val = 32'd2; rt_val = 32'd3;
    snap(1'b0, 1'b0, m_hi, m_lo);
    start = 1'b0; flush = 1'b0;
    snap(1'b0, 1'b0, m_hi, m_lo);
    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD_BEEF;
    snap(1'b0, 1'b1, m_hi, m_lo);
    start = 1'b0;
    snap(1'b0, 1'b0, m_hi, m_lo);

    // reset three cycles into a div discards it
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    snap(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    snap(1'b0, 1'b0, 32'd0, 32'd0);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    issue(MD_MTHI, 32'hAAAA_5555, 32'd0);
    m_hi = 32'hAAAA_5555;
`ifdef MD_DIVZERO_KEEP_EN
    run_op(MD_DIVU, 32'h0000_0055, 32'd0, 32'hAAAA_5555, 32'h8000_0000, 10);
    run_op(MD_DIV,  32'hFFFF_FF00, 32'd0, 32'hAAAA_5555, 32'h8000_0000, 10);
`else
    run_op(MD_DIVU, 32'h0000_0055, 32'd0, 32'h0000_0055, 32'hFFFF_FFFF, 10);
    run_op(MD_DIV,  32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 10);
`endif

    // back-to-back: second start held until busy drops
    r.hi = 32'd0; r.lo = 32'd42; r.len = 5;
    res_q.push_back(r);
    r.hi = 32'd2; r.lo = 32'd14; r.len = 10;
    res_q.push_back(r);
    issue(MD_MULT, 32'd7, 32'd6);
    start = 1'b1; md_op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    snap(1'b0, 1'b1, 32'd0, 32'd42);
    start = 1'b0;
    snap(1'b1, 1'b1, 32'd0, 32'd42);
    wait_idle();

    @(posedge clk); #1;
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Multi-cycle multiply/divide unit and HI/LO register owner for the pipelined MIPS core. It sits beside the E-stage ALU and accepts mult/multu/div/divu/mthi/mtlo from E. It holds the result for a fixed latency and raises busy. The D-stage hazard logic uses busy to stall mult/div/mfhi/mflo/mthi/mtlo. mfhi/mflo read hi/lo combinationally.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (must be ≥1).
DIV_CYCLES, 10, busy duration for div/divu (must be ≥1).

Ports:
clk  input  1  core clock.
reset  input  1  synchronous, active-high reset.
start  input  1  E-stage instruction is an md operation; one-cycle qualifier.
md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 no-op.
rs_val  input  32  forwarded rs operand.
rt_val  input  32  forwarded rt operand.
flush  input  1  exception/interrupt in M this cycle; suppresses acceptance of start.
busy  output  1  registered; high while a mult/div is in flight.
md_active  output  1  combinational: (start & ~flush) | busy; consumed by the hazard unit.
hi  output  32  HI register.
lo  output  32  LO register.

Behaviour:
- Reset (sync, active-high): state IDLE, counter 0, busy 0, hi 0, lo 0, pending result 0. Reset wins over every other input in the same cycle, including mid-operation; any in-flight result is discarded.
- FSM states: IDLE, BUSY.
- IDLE, start=1, flush=0:
  - mult/multu: at the edge, compute the full 64-bit result into the pending registers. mult is signed {hi,lo}=rs*rt; multu is unsigned. Load counter=MULT_CYCLES, set busy=1, go to BUSY.
  - div/divu: pending lo = quotient, pending hi = remainder, signed or unsigned. Signed results truncate toward zero; remainder sign follows the dividend. Load counter=DIV_CYCLES, set busy=1, go to BUSY.
  - mthi/mtlo: hi (or lo) ← rs_val at that edge. No busy, stay IDLE.
  - md_op 6–7: no effect.
- flush=1: start is ignored entirely, with no HI/LO write and no busy.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==1: commit pending to hi/lo, busy←0, go to IDLE.
  - busy is therefore high for exactly N cycles after the accept edge, and hi/lo show the new value in the first cycle busy is low.
  - hi/lo hold their old values throughout BUSY; mfhi/mflo must be stalled by the hazard unit.
- start while BUSY: ignored, since the hazard unit guarantees it cannot occur; no state change. flush during BUSY does not cancel the operation, because the instruction has already committed past E.
- Arithmetic: operands are 32-bit. Products are 64-bit, with signed extension for mult. div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: see Optional Feature.

Optional Feature:
Macro MD_DIVZERO_KEEP_EN.
- Defined: div/divu with rt_val==0 is accepted and raises busy for DIV_CYCLES, but hi/lo are left unchanged at commit.
- Undefined: divide by zero commits lo=0xFFFFFFFF and hi=rs_val, for both signed and unsigned.

Decomposition:
- Shared package/header: md_op encodings (MD_MULT..MD_MTLO), default latency constants, FSM state encodings.
- One natural sub-module: md_arith. It is purely combinational, takes (md_op, rs_val, rt_val) and returns the 64-bit {hi,lo} result including the divide-by-zero rule. md_sequencer instantiates it and owns the FSM, counter and registers.

Test Plan:
- mult rs=0xFFFFFFFD (−3), rt=5 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- div rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=2 → lo=3, hi=1.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 on consecutive cycles → busy stays 0; hi and lo update the edge after each; md_active high only while start=1.
- start=1 with flush=1 (mult 2*3) → busy stays 0, hi/lo unchanged. Assert reset 3 cycles into a div → next cycle busy=0, hi=lo=0, state IDLE.
- div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0. divu rs=0x55, rt=0 → with MD_DIVZERO_KEEP_EN hi/lo keep prior values; without it lo=0xFFFFFFFF, hi=0x00000055; busy 10 cycles either way.
- Back-to-back: mult accepted, then a second start held until the cycle busy falls → second op accepted that cycle; first result visible before second commit.
